multicycle_controller: RTL and testbench

Parametrised multi-cycle control unit for the RV32I core, replacing the single-cycle decoder's tie-high pc_write/ir_write.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK states.
- Handshakes with instruction and data memories of variable latency.
- Drives the datapath muxes, PC, IR and register-file enables.
- Maintains a retired-instruction counter and a memory-timeout fault.

---
 rtl/multicycle_pkg.sv | 55 +++++
 rtl/multicycle_controller_wait_timer.sv | 34 +++
 rtl/multicycle_controller.sv | 151 +++++++++++++++
 tb/tb_multicycle_controller.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the RV32I multi-cycle control unit.
// Holds the state enum, base-opcode constants, mux-select encodings and the
// opcode-to-ALU-operand mapping used by the controller.
package multicycle_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_FAULT     = 3'd5,
    S_TRAP      = 3'd6
  } state_t;

  // RV32I base opcodes (instruction[6:0])
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  // mem_to_reg: register-file write-data source
  localparam logic [1:0] M2R_IMM = 2'd0;
  localparam logic [1:0] M2R_ALU = 2'd1;
  localparam logic [1:0] M2R_PC4 = 2'd2;
  localparam logic [1:0] M2R_MEM = 2'd3;

  // alu_src: bit0 selects rs1 (1) / pc (0), bit1 selects imm (1) / rs2 (0)
  localparam logic [1:0] ALU_PC_RS2  = 2'b00;
  localparam logic [1:0] ALU_RS1_RS2 = 2'b01;
  localparam logic [1:0] ALU_PC_IMM  = 2'b10;
  localparam logic [1:0] ALU_RS1_IMM = 2'b11;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC: return 1'b1;
      default:                                                return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] alu_src_for(input logic [6:0] op);
    case (op)
      OP:                         return ALU_RS1_RS2;
      OP_IMM, LOAD, STORE, JALR:  return ALU_RS1_IMM;
      BRANCH, JAL, AUIPC:         return ALU_PC_IMM;
      default:                    return ALU_PC_RS2;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_wait_timer.sv
// mc_wait_timer: counts consecutive not-ready cycles of a memory handshake.
// Latency: timeout is combinational on the current count and ready.
// Backpressure: none; the count clears whenever the handshake is not waiting.
// Ports: clk, reset (sync, active-high), waiting (in FETCH/MEM), ready (the
//        handshake's ready), timeout (this is the last allowed wait cycle).
module mc_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic ready,
  output logic timeout
);

  // Timeout fires on the MEM_TIMEOUT-th consecutive not-ready cycle, so the
  // state leaves to FAULT after exactly MEM_TIMEOUT wait cycles. A ready in
  // that same cycle masks the timeout and the access completes normally.
  localparam logic [TMO_W-1:0] LAST = TMO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || !waiting || ready) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign timeout = (MEM_TIMEOUT > 0) && waiting && !ready && (cnt == LAST);

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer for RV32I.
// Latency: 4 cycles (ALU/jump/branch), 3 (LUI), 5+ (load/store) plus memory waits.
// Backpressure: stalls in FETCH/MEM until imem_ready/dmem_ready; faults after
//   MEM_TIMEOUT wait cycles (0 disables). Optional macro: ILLEGAL_TRAP_EN makes
//   an illegal opcode enter an absorbing TRAP state instead of retiring as NOP.
// Ports: clk, reset (sync, active-high); opcode, branch_cond, imem_ready,
//   dmem_ready in; memory strobes, datapath enables/selects, instret, fault,
//   state_o (debug) out.
module multicycle_controller
  import multicycle_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32,
  parameter int TMO_W       = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             branch_cond,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic [1:0]       alu_src,
  output logic [1:0]       mem_to_reg,
  output logic [CNT_W-1:0] instret,
  output logic             fault,
  output logic [2:0]       state_o
);

  state_t state, state_nxt;
  logic   waiting, wait_ready, timeout;

  assign waiting    = (state == S_FETCH) || (state == S_MEM);
  assign wait_ready = (state == S_FETCH) ? imem_ready : dmem_ready;

  mc_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TMO_W       (TMO_W)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .waiting (waiting),
    .ready   (wait_ready),
    .timeout (timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      instret <= '0;
      fault   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_WRITEBACK) begin
        instret <= instret + CNT_W'(1);
      end
      if (state_nxt == S_FAULT) begin
        fault <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    alu_src    = ALU_PC_RS2;
    mem_to_reg = M2R_IMM;

    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
        if (imem_ready)   state_nxt = S_DECODE;
        else if (timeout) state_nxt = S_FAULT;
      end
      S_DECODE: begin
        if (opcode == LUI) begin
          state_nxt = S_WRITEBACK;
        end else if (!is_legal(opcode)) begin
`ifdef ILLEGAL_TRAP_EN
          state_nxt = S_TRAP;
`else
          state_nxt = S_WRITEBACK;
`endif
        end else begin
          state_nxt = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        alu_src   = alu_src_for(opcode);
        state_nxt = (opcode == LOAD || opcode == STORE) ? S_MEM : S_WRITEBACK;
      end
      S_MEM: begin
        alu_src   = alu_src_for(opcode);
        dmem_req  = 1'b1;
        mem_read  = (opcode == LOAD);
        mem_write = (opcode == STORE);
        if (dmem_ready)   state_nxt = S_WRITEBACK;
        else if (timeout) state_nxt = S_FAULT;
      end
      S_WRITEBACK: begin
        // Illegal opcodes fall through every case below and retire as a NOP.
        alu_src  = alu_src_for(opcode);
        pc_write = 1'b1;
        case (opcode)
          OP, OP_IMM, AUIPC: begin reg_write = 1'b1; mem_to_reg = M2R_ALU; end
          LOAD:              begin reg_write = 1'b1; mem_to_reg = M2R_MEM; end
          LUI:               begin reg_write = 1'b1; mem_to_reg = M2R_IMM; end
          JAL, JALR:         begin reg_write = 1'b1; mem_to_reg = M2R_PC4; pc_src = 1'b1; end
          BRANCH:            pc_src = branch_cond;
          default:           ;
        endcase
        state_nxt = S_FETCH;
      end
      S_FAULT, S_TRAP: state_nxt = state;
      default:         state_nxt = S_FETCH;
    endcase

    // Reset is synchronous, so state may still be mid-instruction this cycle;
    // silence every strobe so no memory access or register write leaks out.
    if (reset) begin
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      reg_write  = 1'b0;
      alu_src    = ALU_PC_RS2;
      mem_to_reg = M2R_IMM;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  localparam int TMO = 4;
  localparam int CW  = 4;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LD    = 7'b0000011;
  localparam logic [6:0] OPC_ST    = 7'b0100011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  logic [6:0] legal_ops [9] = '{OPC_OP, OPC_IMM, OPC_LD, OPC_ST, OPC_BR,
                                OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC};

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [6:0]    opcode = '0;
  logic          branch_cond = 1'b0;
  logic          imem_ready = 1'b0;
  logic          dmem_ready = 1'b0;
  logic          imem_req, dmem_req, mem_read, mem_write, ir_write;
  logic          pc_write, pc_src, reg_write, fault;
  logic [1:0]    alu_src, mem_to_reg;
  logic [CW-1:0] instret;
  logic [2:0]    state_o;

  int checks = 0;
  int failures = 0;
  int retired = 0;

  multicycle_controller #(
    .MEM_TIMEOUT (TMO),
    .CNT_W       (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .branch_cond (branch_cond),
    .imem_ready  (imem_ready),
    .dmem_ready  (dmem_ready),
    .imem_req    (imem_req),
    .dmem_req    (dmem_req),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .reg_write   (reg_write),
    .alu_src     (alu_src),
    .mem_to_reg  (mem_to_reg),
    .instret     (instret),
    .fault       (fault),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  // {state[19:17], imem_req, dmem_req, mem_read, mem_write, ir_write,
  //  pc_write, pc_src, reg_write [16:9], alu_src[8:7], mem_to_reg[6:5],
  //  fault[4], instret[3:0]}
  logic [19:0] obs;
  assign obs = {state_o, imem_req, dmem_req, mem_read, mem_write, ir_write,
                pc_write, pc_src, reg_write, alu_src, mem_to_reg, fault, instret};

  // ---------------- reference rules ----------------
  function automatic bit is_legal_tb(input logic [6:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] exp_alu(input logic [6:0] op);
    if (op == OPC_OP) return 2'b01;
    if (op == OPC_IMM || op == OPC_LD || op == OPC_ST || op == OPC_JALR) return 2'b11;
    if (op == OPC_BR || op == OPC_JAL || op == OPC_AUIPC) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic exp_regw(input logic [6:0] op);
    return (op == OPC_OP || op == OPC_IMM || op == OPC_LD || op == OPC_LUI ||
            op == OPC_AUIPC || op == OPC_JAL || op == OPC_JALR);
  endfunction

  function automatic logic [1:0] exp_m2r(input logic [6:0] op);
    if (op == OPC_OP || op == OPC_IMM || op == OPC_AUIPC) return 2'd1;
    if (op == OPC_LD) return 2'd3;
    if (op == OPC_JAL || op == OPC_JALR) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic exp_pcsrc(input logic [6:0] op, input logic bc);
    return (op == OPC_JAL) || (op == OPC_JALR) || (op == OPC_BR && bc);
  endfunction

  function automatic logic [15:0] mk(input logic [2:0] st, input logic imr, input logic dmr,
                                     input logic mrd, input logic mwr, input logic irw,
                                     input logic pcw, input logic pcs, input logic rgw,
                                     input logic [1:0] alu, input logic [1:0] m2r, input logic flt);
    return {st, imr, dmr, mrd, mwr, irw, pcw, pcs, rgw, alu, m2r, flt};
  endfunction

  // ---------------- checking ----------------
  task automatic check_raw(input string tag, input logic [19:0] o, input logic [19:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h (state,strobes,alu,m2r,fault,instret)", tag, o, e);
    end
  endtask

  task automatic check_ctl(input string tag, input logic [15:0] ctl);
    check_raw(tag, obs, {ctl, CW'(retired)});
  endtask

  task automatic noise();
    imem_ready = 1'($urandom);
    dmem_ready = 1'($urandom);
  endtask

  task automatic do_reset(input int n);
    retired = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b1;
      noise();
      opcode = 7'($urandom);
      #1;
      check_raw("reset_strobes", {12'd0, obs[16:9]}, 20'd0);
      if (i > 0) check_ctl("reset_state", mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic expect_fault();
    check_ctl("fault_entry", mk(3'd5, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      noise();
      opcode = 7'($urandom);
      #1 check_ctl("fault_hold", mk(3'd5, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1));
    end
  endtask

  // One instruction: fw/mw = not-ready cycles before the fetch/data ready;
  // rst_at = MEM cycle index at which to abandon the instruction for a reset.
  task automatic run_instr(input logic [6:0] op, input logic bc, input int fw,
                           input int mw, input int rst_at);
    bit         legal, is_ld, is_st;
    logic [1:0] alu;
    legal = is_legal_tb(op);
    is_ld = (op == OPC_LD);
    is_st = (op == OPC_ST);
    alu   = exp_alu(op);

    for (int k = 0; k <= fw; k++) begin
      @(negedge clk);
      opcode      = 7'($urandom);
      imem_ready  = (k == fw);
      dmem_ready  = 1'($urandom);
      branch_cond = 1'($urandom);
      #1;
      if (k == TMO) begin expect_fault(); return; end
      check_ctl("fetch", mk(3'd0, 1, 0, 0, 0, k == fw, 0, 0, 0, 2'b00, 2'b00, 0));
    end

    @(negedge clk);
    opcode      = op;
    branch_cond = bc;
    noise();
    #1 check_ctl("decode", mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));

`ifdef ILLEGAL_TRAP_EN
    if (!legal) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        noise();
        #1 check_ctl("trap", mk(3'd6, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
      end
      return;
    end
`endif

    if (legal && op != OPC_LUI) begin
      @(negedge clk);
      noise();
      #1 check_ctl("execute", mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, alu, 2'b00, 0));
    end

    if (is_ld || is_st) begin
      for (int k = 0; k <= mw; k++) begin
        if (k == rst_at) return;
        @(negedge clk);
        imem_ready = 1'($urandom);
        dmem_ready = (k == mw);
        #1;
        if (k == TMO) begin expect_fault(); return; end
        check_ctl("mem", mk(3'd3, 0, 1, is_ld, is_st, 0, 0, 0, 0, alu, 2'b00, 0));
      end
    end

    @(negedge clk);
    noise();
    #1 check_ctl("writeback", mk(3'd4, 0, 0, 0, 0, 0, 1, exp_pcsrc(op, bc), exp_regw(op),
                                 alu, exp_m2r(op), 0));
    retired++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] op;
    do_reset(2);

    // directed: ALU-immediate, load with 3 MEM cycles, taken/not-taken branch
    run_instr(OPC_IMM, 1'b0, 0, 0, -1);
    run_instr(OPC_LD, 1'b0, 0, 2, -1);
    run_instr(OPC_BR, 1'b1, 0, 0, -1);
    run_instr(OPC_BR, 1'b0, 0, 0, -1);
    // ready on the last allowed wait cycle completes normally
    run_instr(OPC_ST, 1'b0, 0, TMO - 1, -1);
    run_instr(OPC_OP, 1'b0, TMO - 1, 0, -1);
    run_instr(OPC_JAL, 1'b0, 1, 0, -1);
    run_instr(OPC_JALR, 1'b1, 0, 0, -1);
    run_instr(OPC_LUI, 1'b1, 2, 0, -1);
    run_instr(OPC_AUIPC, 1'b0, 0, 0, -1);

    // randomized sequence; instret (4 bits) wraps several times
    for (int n = 0; n < 48; n++) begin
      op = legal_ops[$urandom_range(0, 8)];
`ifndef ILLEGAL_TRAP_EN
      if ($urandom_range(0, 7) == 0) op = 7'($urandom);
`endif
      run_instr(op, 1'($urandom), $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1), -1);
    end

    // illegal opcode: NOP retire by default, absorbing TRAP when enabled
    run_instr(7'b1111111, 1'b1, 0, 0, -1);
`ifdef ILLEGAL_TRAP_EN
    do_reset(2);
`endif
    run_instr(OPC_IMM, 1'b0, 0, 0, -1);

    // data-memory timeout on a store, then recovery by reset
    run_instr(OPC_ST, 1'b0, 0, TMO + 3, -1);
    do_reset(2);
    run_instr(OPC_OP, 1'b0, 0, 0, -1);

    // instruction-memory timeout
    run_instr(OPC_OP, 1'b0, TMO + 3, 0, -1);
    do_reset(2);

    // reset while a load is outstanding in MEM
    run_instr(OPC_IMM, 1'b0, 0, 0, -1);
    run_instr(OPC_LD, 1'b0, 0, 10, 2);
    do_reset(2);
    run_instr(OPC_LD, 1'b0, 1, 1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
